// File: rtl/alu_retry_controller_pkg.sv
// -----------------------------------------------------------------------------
// alu_retry_controller_pkg
// Shared definitions for the ALU retry controller slice:
//   - ALU opcode constants driven on alu_op
//   - bit positions inside the 4-bit ALU error-flag vector
//   - FSM state encoding (also exported as a debug output)
//   - helper that packs the ALU status bits into the response flag vector
// -----------------------------------------------------------------------------
package alu_retry_controller_pkg;

  localparam int DATA_W  = 16;
  localparam int OP_W    = 4;
  localparam int EFLAG_W = 4;
  localparam int RFLAG_W = 3;

  // ALU opcodes
  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;

  // Error-flag bit positions: {parity, residue3, residue5, carry}
  localparam int ERR_PARITY_BIT = 3;
  localparam int ERR_RES3_BIT   = 2;
  localparam int ERR_RES5_BIT   = 1;
  localparam int ERR_CARRY_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Response flag order is {cout, zero, overflow}.
  function automatic logic [RFLAG_W-1:0] pack_flags(input logic cout,
                                                     input logic zero,
                                                     input logic overflow);
    return {cout, zero, overflow};
  endfunction

endpackage

// File: rtl/alu_retry_controller_if.sv
// -----------------------------------------------------------------------------
// alu_retry_controller_if
// Bundles every non-clock/reset signal of the retry controller.
//   master : the requester / ALU / response consumer side
//   slave  : the controller itself
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising clk
// edge where valid and ready are both high; the offering side keeps its
// payload stable while valid is high and ready is low.
// Groups:
//   req_*   request channel (valid/ready, operands, opcode)
//   alu_*   operands out to the ALU, registered results/error status back
//   rsp_*   response channel (valid/ready, result, flags, fault, retries)
//   err_count/fault_count/last_err_flags/clr_counts  error statistics
// -----------------------------------------------------------------------------
interface alu_retry_controller_if #(
  parameter int CNT_W = 8
);
  import alu_retry_controller_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [DATA_W-1:0]  req_a;
  logic [DATA_W-1:0]  req_b;
  logic [OP_W-1:0]    req_op;

  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [OP_W-1:0]    alu_op;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_cout;
  logic               alu_zero;
  logic               alu_overflow;
  logic               alu_error;
  logic [EFLAG_W-1:0] alu_err_flags;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_result;
  logic [RFLAG_W-1:0] rsp_flags;
  logic               rsp_fault;
  logic [1:0]         rsp_retries;

  logic [CNT_W-1:0]   err_count;
  logic [CNT_W-1:0]   fault_count;
  logic [EFLAG_W-1:0] last_err_flags;
  logic               clr_counts;

  modport master (
    output req_valid, req_a, req_b, req_op,
    output alu_result, alu_cout, alu_zero, alu_overflow, alu_error, alu_err_flags,
    output rsp_ready, clr_counts,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_result, rsp_flags, rsp_fault, rsp_retries,
    input  err_count, fault_count, last_err_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  alu_result, alu_cout, alu_zero, alu_overflow, alu_error, alu_err_flags,
    input  rsp_ready, clr_counts,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_result, rsp_flags, rsp_fault, rsp_retries,
    output err_count, fault_count, last_err_flags
  );

endinterface

// File: rtl/alu_retry_controller_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the error and fault totals.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_inc       count up by one (holds at all-ones)
//   i_clr       synchronous clear, wins over i_inc
//   o_count     current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/alu_retry_controller.sv
// -----------------------------------------------------------------------------
// alu_retry_controller
// Issues one operation at a time to a fault-tolerant ALU, checks its error
// output and re-issues the same operands up to MAX_RETRY times. Once the
// retries are used up the last result is returned with rsp_fault set.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         alu_retry_controller_if.slave (request, ALU, response, stats)
//   o_state     current FSM state, for debug/observation
// Timing: ISSUE gives the ALU one cycle with stable operands, CHECK samples
// its registered outputs. Each retry is one more ISSUE/CHECK pair.
// -----------------------------------------------------------------------------
module alu_retry_controller
  import alu_retry_controller_pkg::*;
#(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_retry_controller_if.slave bus,
  output state_t o_state
);

  localparam int RETRY_W = 2;
  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

  state_t              r_state;
  state_t              w_next_state;
  logic [RETRY_W-1:0]  r_retry_cnt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic [DATA_W-1:0]   r_rsp_result;
  logic [RFLAG_W-1:0]  r_rsp_flags;
  logic                r_rsp_fault;
  logic [RETRY_W-1:0]  r_rsp_retries;
  logic [EFLAG_W-1:0]  r_last_err_flags;
  logic [CNT_W-1:0]    w_err_count;
  logic [CNT_W-1:0]    w_fault_count;

  logic w_accept;
  logic w_pass;
  logic w_retry;
  logic w_fault;
  logic w_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-cycle event strobes
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_pass       = 1'b0;
    w_retry      = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (!bus.alu_error) begin
          w_pass       = 1'b1;
          w_next_state = ST_RESP;
        end else if (r_retry_cnt < MAX_RETRY_C) begin
          w_retry      = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_fault      = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        // Returning to IDLE first is what blocks acceptance in the exit cycle.
        if (bus.rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_err = w_retry | w_fault;

  // Operand capture, retry bookkeeping and response registers. Operands are
  // only loaded on accept, so they stay fixed across every re-issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_retry_cnt   <= '0;
      r_rsp_result  <= '0;
      r_rsp_flags   <= '0;
      r_rsp_fault   <= 1'b0;
      r_rsp_retries <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a     <= bus.req_a;
        r_alu_b     <= bus.req_b;
        r_alu_op    <= bus.req_op;
        r_retry_cnt <= '0;
      end else if (w_retry) begin
        r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
      end
      if (w_pass || w_fault) begin
        r_rsp_result  <= bus.alu_result;
        r_rsp_flags   <= pack_flags(bus.alu_cout, bus.alu_zero, bus.alu_overflow);
        r_rsp_fault   <= w_fault;
        r_rsp_retries <= r_retry_cnt;
      end
    end
  end

  // Last error flags share the counters' clear, which wins over a new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_err_flags <= '0;
    end else if (bus.clr_counts) begin
      r_last_err_flags <= '0;
    end else if (w_err) begin
      r_last_err_flags <= bus.alu_err_flags;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_err),
    .i_clr   (bus.clr_counts),
    .o_count (w_err_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_fault_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_fault),
    .i_clr   (bus.clr_counts),
    .o_count (w_fault_count)
  );

  assign bus.req_ready      = (r_state == ST_IDLE);
  assign bus.rsp_valid      = (r_state == ST_RESP);
  assign bus.alu_a          = r_alu_a;
  assign bus.alu_b          = r_alu_b;
  assign bus.alu_op         = r_alu_op;
  assign bus.rsp_result     = r_rsp_result;
  assign bus.rsp_flags      = r_rsp_flags;
  assign bus.rsp_fault      = r_rsp_fault;
  assign bus.rsp_retries    = r_rsp_retries;
  assign bus.err_count      = w_err_count;
  assign bus.fault_count    = w_fault_count;
  assign bus.last_err_flags = r_last_err_flags;
  assign o_state            = r_state;

endmodule

// File: tb/tb_alu_retry_controller.sv
// -----------------------------------------------------------------------------
// tb_alu_retry_controller
// Directed bench for alu_retry_controller. Two instances share all stimulus:
// dut uses CNT_W=8, dut2 uses CNT_W=2 so counter saturation can be observed.
// The ALU is a small behavioural model answering from the dut's alu_* outputs;
// alu_error/alu_err_flags are driven by the scenario tasks.
// Latency convention: k counts falling edges after the accept edge N; the
// value seen at falling edge k is the value sampled by rising edge N+k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_retry_controller;
  import alu_retry_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic        req_valid = 1'b0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic        rsp_ready = 1'b0;
  logic        alu_error = 1'b0;
  logic [3:0]  alu_err_flags = '0;
  logic        clr_counts = 1'b0;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  alu_retry_controller_if #(.CNT_W(8)) bus ();
  alu_retry_controller_if #(.CNT_W(2)) bus2 ();
  state_t state;
  state_t state2;

  alu_retry_controller #(.MAX_RETRY(2), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (state)
  );

  alu_retry_controller #(.MAX_RETRY(2), .CNT_W(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus2),
    .o_state (state2)
  );

  // ---------------- ALU model ----------------
  logic [16:0] m_sum;
  logic        m_ovf;
  always_comb begin
    m_sum = 17'd0;
    m_ovf = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        m_ovf = (bus.alu_a[15] == bus.alu_b[15]) && (m_sum[15] != bus.alu_a[15]);
      end
      OP_SUB: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
        m_ovf = (bus.alu_a[15] != bus.alu_b[15]) && (m_sum[15] != bus.alu_a[15]);
      end
      OP_AND:  m_sum = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:   m_sum = {1'b0, bus.alu_a | bus.alu_b};
      default: m_sum = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
  end

  assign bus.req_valid      = req_valid;
  assign bus.req_a          = req_a;
  assign bus.req_b          = req_b;
  assign bus.req_op         = req_op;
  assign bus.rsp_ready      = rsp_ready;
  assign bus.alu_error      = alu_error;
  assign bus.alu_err_flags  = alu_err_flags;
  assign bus.clr_counts     = clr_counts;
  assign bus.alu_result     = m_sum[15:0];
  assign bus.alu_cout       = m_sum[16];
  assign bus.alu_zero       = (m_sum[15:0] == 16'd0);
  assign bus.alu_overflow   = m_ovf;

  assign bus2.req_valid     = req_valid;
  assign bus2.req_a         = req_a;
  assign bus2.req_b         = req_b;
  assign bus2.req_op        = req_op;
  assign bus2.rsp_ready     = rsp_ready;
  assign bus2.alu_error     = alu_error;
  assign bus2.alu_err_flags = alu_err_flags;
  assign bus2.clr_counts    = clr_counts;
  assign bus2.alu_result    = m_sum[15:0];
  assign bus2.alu_cout      = m_sum[16];
  assign bus2.alu_zero      = (m_sum[15:0] == 16'd0);
  assign bus2.alu_overflow  = m_ovf;

  // ---------------- driver ----------------
  // err_mode: 0 no error, 1 error on first CHECK only, 2 error stuck high.
  // hold: falling edges rsp_ready is kept low after rsp_valid is seen.
  // poke: offer a second request (a=DEAD) during hold and the exit edge.
  // clr_at: falling edge index at which clr_counts is pulsed for one edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input int err_mode, input logic [3:0] eflags, input int hold,
                        input bit poke, input int clr_at,
                        output int lat, output logic [15:0] res, output logic [2:0] flg,
                        output logic flt, output logic [1:0] rty, output logic stable,
                        output logic post_ready, output logic [15:0] post_alu_a);
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1; rsp_ready = 1'b0;
    alu_error = (err_mode != 0); alu_err_flags = eflags;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      clr_counts = (k == clr_at);
      if (err_mode == 1 && k == 3) alu_error = 1'b0;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    clr_counts = 1'b0;
    res = bus.rsp_result; flg = bus.rsp_flags; flt = bus.rsp_fault; rty = bus.rsp_retries;
    stable = (lat > 0);
    post_ready = 1'b0;
    post_alu_a = '0;
    if (lat > 0) begin
      if (poke) begin
        req_a = 16'hDEAD; req_b = 16'h0001; req_op = OP_ADD; req_valid = 1'b1;
      end
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.req_ready || bus.rsp_result !== res || bus.rsp_flags !== flg ||
            bus.rsp_fault !== flt || bus.rsp_retries !== rty || bus.alu_a !== a)
          stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      post_ready = bus.req_ready;
      post_alu_a = bus.alu_a;
      req_valid = 1'b0;
    end
    alu_error = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++; if (state !== ST_IDLE) begin miss_cnt++; $display("FAIL reset_state got %0d want %0d", state, ST_IDLE); end
    vec_cnt++; if (bus.req_ready !== 1'b1) begin miss_cnt++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    vec_cnt++; if (bus.rsp_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    vec_cnt++; if ({bus.rsp_result, bus.rsp_flags, bus.rsp_fault, bus.rsp_retries} !== 22'd0) begin
      miss_cnt++; $display("FAIL reset_rsp got %h/%b/%b/%0d want 0", bus.rsp_result, bus.rsp_flags, bus.rsp_fault, bus.rsp_retries); end
    vec_cnt++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 36'd0) begin
      miss_cnt++; $display("FAIL reset_alu got %h/%h/%h want 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    vec_cnt++; if (bus.err_count !== 8'd0 || bus.fault_count !== 8'd0 || bus.last_err_flags !== 4'd0) begin
      miss_cnt++; $display("FAIL reset_counts got %0d/%0d/%b want 0/0/0000", bus.err_count, bus.fault_count, bus.last_err_flags); end
  endtask

  task automatic test_add_basic();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    run_op(16'h1234, 16'h0001, OP_ADD, 0, 4'b0000, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (lat !== 3) begin miss_cnt++; $display("FAIL add_latency got %0d want 3", lat); end
    vec_cnt++; if (res !== 16'h1235) begin miss_cnt++; $display("FAIL add_result got %h want 1235", res); end
    vec_cnt++; if (flg !== 3'b000) begin miss_cnt++; $display("FAIL add_flags got %b want 000", flg); end
    vec_cnt++; if (flt !== 1'b0 || rty !== 2'd0) begin miss_cnt++; $display("FAIL add_fault_retries got %b/%0d want 0/0", flt, rty); end
    vec_cnt++; if (pr !== 1'b1) begin miss_cnt++; $display("FAIL add_back_to_idle got %b want 1", pr); end
  endtask

  task automatic test_patterns();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    run_op(16'hFFFF, 16'h0001, OP_ADD, 0, 4'b0000, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (res !== 16'h0000 || flg !== 3'b110) begin miss_cnt++; $display("FAIL add_wrap got %h/%b want 0000/110", res, flg); end
    run_op(16'h8000, 16'h0001, OP_SUB, 0, 4'b0000, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (res !== 16'h7FFF || flg !== 3'b101) begin miss_cnt++; $display("FAIL sub_ovf got %h/%b want 7fff/101", res, flg); end
    run_op(16'hF0F0, 16'h0F0F, OP_AND, 0, 4'b0000, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (res !== 16'h0000 || flg !== 3'b010) begin miss_cnt++; $display("FAIL and_zero got %h/%b want 0000/010", res, flg); end
    vec_cnt++; if (lat !== 3) begin miss_cnt++; $display("FAIL and_latency got %0d want 3", lat); end
  endtask

  task automatic test_single_retry();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    run_op(16'h0010, 16'h0020, OP_ADD, 1, 4'b1000, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (lat !== 5) begin miss_cnt++; $display("FAIL retry1_latency got %0d want 5", lat); end
    vec_cnt++; if (res !== 16'h0030 || flt !== 1'b0) begin miss_cnt++; $display("FAIL retry1_result got %h/%b want 0030/0", res, flt); end
    vec_cnt++; if (rty !== 2'd1) begin miss_cnt++; $display("FAIL retry1_retries got %0d want 1", rty); end
    vec_cnt++; if (bus.err_count !== 8'd1 || bus.fault_count !== 8'd0) begin
      miss_cnt++; $display("FAIL retry1_counts got %0d/%0d want 1/0", bus.err_count, bus.fault_count); end
    vec_cnt++; if (bus.last_err_flags !== 4'b1000) begin miss_cnt++; $display("FAIL retry1_last_flags got %b want 1000", bus.last_err_flags); end
  endtask

  task automatic test_retry_exhausted();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    run_op(16'h0001, 16'h0001, OP_ADD, 2, 4'b0011, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (lat !== 7) begin miss_cnt++; $display("FAIL fault_latency got %0d want 7", lat); end
    vec_cnt++; if (flt !== 1'b1 || rty !== 2'd2) begin miss_cnt++; $display("FAIL fault_rsp got %b/%0d want 1/2", flt, rty); end
    vec_cnt++; if (res !== 16'h0002) begin miss_cnt++; $display("FAIL fault_result got %h want 0002", res); end
    // 1 from the single-retry scenario plus 3 here.
    vec_cnt++; if (bus.err_count !== 8'd4 || bus.fault_count !== 8'd1) begin
      miss_cnt++; $display("FAIL fault_counts got %0d/%0d want 4/1", bus.err_count, bus.fault_count); end
    vec_cnt++; if (bus.last_err_flags !== 4'b0011) begin miss_cnt++; $display("FAIL fault_last_flags got %b want 0011", bus.last_err_flags); end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    run_op(16'h00FF, 16'h0F0F, OP_AND, 0, 4'b0000, 5, 1'b1, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (res !== 16'h000F || flg !== 3'b000) begin miss_cnt++; $display("FAIL bp_result got %h/%b want 000f/000", res, flg); end
    vec_cnt++; if (st !== 1'b1) begin miss_cnt++; $display("FAIL bp_stable got %b want 1", st); end
    vec_cnt++; if (pr !== 1'b1 || pa !== 16'h00FF) begin miss_cnt++; $display("FAIL bp_exit_no_accept got %b/%h want 1/00ff", pr, pa); end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    vec_cnt++; if (bus.err_count !== 8'd0 || bus.fault_count !== 8'd0 || bus.last_err_flags !== 4'd0) begin
      miss_cnt++; $display("FAIL clr_counts got %0d/%0d/%b want 0/0/0000", bus.err_count, bus.fault_count, bus.last_err_flags); end
    for (int i = 0; i < 4; i++)
      run_op(16'h0005, 16'h0005, OP_SUB, 2, 4'b0100, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (bus2.fault_count !== 2'd3 || bus2.err_count !== 2'd3) begin
      miss_cnt++; $display("FAIL sat_w2 got %0d/%0d want 3/3", bus2.fault_count, bus2.err_count); end
    vec_cnt++; if (bus.fault_count !== 8'd4 || bus.err_count !== 8'd12) begin
      miss_cnt++; $display("FAIL sat_w8 got %0d/%0d want 4/12", bus.fault_count, bus.err_count); end
  endtask

  task automatic test_clr_priority();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    // Last CHECK of a stuck-error op is on rising edge N+6; clear on that edge.
    run_op(16'h7FFF, 16'h0001, OP_ADD, 2, 4'b0001, 0, 1'b0, 6, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (flt !== 1'b1 || res !== 16'h8000 || flg !== 3'b001) begin
      miss_cnt++; $display("FAIL clrpri_rsp got %b/%h/%b want 1/8000/001", flt, res, flg); end
    vec_cnt++; if (bus.err_count !== 8'd0 || bus.fault_count !== 8'd0 || bus.last_err_flags !== 4'd0) begin
      miss_cnt++; $display("FAIL clrpri_w8 got %0d/%0d/%b want 0/0/0000", bus.err_count, bus.fault_count, bus.last_err_flags); end
    vec_cnt++; if (bus2.err_count !== 2'd0 || bus2.fault_count !== 2'd0) begin
      miss_cnt++; $display("FAIL clrpri_w2 got %0d/%0d want 0/0", bus2.err_count, bus2.fault_count); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] res, pa; logic [2:0] flg; logic flt, st, pr; logic [1:0] rty;
    logic seen_rsp;
    run_op(16'h0100, 16'h0200, OP_ADD, 1, 4'b0010, 0, 1'b0, 0, lat, res, flg, flt, rty, st, pr, pa);
    vec_cnt++; if (bus.err_count !== 8'd1) begin miss_cnt++; $display("FAIL mid_pre_count got %0d want 1", bus.err_count); end
    @(negedge clk);
    req_a = 16'h4444; req_b = 16'h1111; req_op = OP_ADD; req_valid = 1'b1; alu_error = 1'b1;
    alu_err_flags = 4'b1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vec_cnt++; if (state !== ST_CHECK) begin miss_cnt++; $display("FAIL mid_in_check got %0d want %0d", state, ST_CHECK); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (state !== ST_IDLE || bus.rsp_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL mid_async_state got %0d/%b want 0/0", state, bus.rsp_valid); end
    vec_cnt++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 36'd0 || bus.rsp_result !== 16'd0) begin
      miss_cnt++; $display("FAIL mid_async_data got %h/%h want 0/0", bus.alu_a, bus.rsp_result); end
    vec_cnt++; if (bus.err_count !== 8'd0 || bus.last_err_flags !== 4'd0) begin
      miss_cnt++; $display("FAIL mid_async_counts got %0d/%b want 0/0000", bus.err_count, bus.last_err_flags); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    alu_error = 1'b0;
    seen_rsp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_rsp = 1'b1;
    end
    vec_cnt++; if (seen_rsp !== 1'b0 || bus.req_ready !== 1'b1) begin
      miss_cnt++; $display("FAIL mid_no_response got rsp %b ready %b want 0/1", seen_rsp, bus.req_ready); end
    vec_cnt++; if (bus.err_count !== 8'd0 || bus.fault_count !== 8'd0) begin
      miss_cnt++; $display("FAIL mid_post_counts got %0d/%0d want 0/0", bus.err_count, bus.fault_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_basic();
    test_patterns();
    test_single_retry();
    test_retry_exhausted();
    test_backpressure();
    test_saturation();
    test_clr_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 ns, %0d vectors applied", vec_cnt);
    $fatal(1);
  end

endmodule

// File: doc/alu_retry_controller.md
ALU_RETRY_CONTROLLER -- requirements
Module: alu_retry_controller

Interface
REQ-001 Parameter MAX_RETRY, default 2, maximum re-issues of one operation after a detected error.
REQ-002 Parameter CNT_W, default 8, width of the error and fault counters.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request offered; req_ready  output  1  request accepted when both high.
REQ-006 req_a, req_b  input  16  operands; req_op  input  4  ALU opcode.
REQ-007 alu_a, alu_b  output  16; alu_op  output  4  operands and opcode driven to the fault-tolerant ALU.
REQ-008 alu_result  input  16; alu_cout, alu_zero, alu_overflow  input  1 each  registered ALU outputs.
REQ-009 alu_error  input  1  combined ALU error; alu_err_flags  input  4  {parity, residue3, residue5, carry}.
REQ-010 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-011 rsp_result  output  16; rsp_flags  output  3  {cout, zero, overflow}; rsp_fault  output  1  retries exhausted; rsp_retries  output  2  re-issues used.
REQ-012 err_count, fault_count  output  CNT_W  error and fault totals; last_err_flags  output  4  flags of last erroneous check; clr_counts  input  1  synchronous counter clear.

Function
REQ-013 FSM states IDLE, ISSUE, CHECK, RESP; req_ready SHALL be high only in IDLE.
REQ-014 IDLE: on req_valid, capture req_a/req_b/req_op into alu_a/alu_b/alu_op, clear retry count, go ISSUE.
REQ-015 ISSUE: one cycle, alu_* held stable, go CHECK; alu_* SHALL stay constant from capture until return to IDLE.
REQ-016 CHECK, alu_error=0: capture result and flags, rsp_fault=0, go RESP.
REQ-017 CHECK, alu_error=1, retry count < MAX_RETRY: increment retry count and err_count, latch last_err_flags, go ISSUE.
REQ-018 CHECK, alu_error=1, retry count = MAX_RETRY: increment err_count and fault_count, latch last_err_flags, capture result, rsp_fault=1, go RESP.
REQ-019 RESP: rsp_valid high; rsp_* stable until rsp_ready; on rsp_ready go IDLE. Back-to-back requests SHALL NOT be accepted in the RESP-exit cycle.
REQ-020 Latency: accept on edge N; error-free rsp_valid asserts after edge N+3; each retry adds 2 cycles.
REQ-021 Counters saturate at all-ones, never wrap.
REQ-022 clr_counts SHALL zero both counters and last_err_flags, with priority over a same-cycle increment.
REQ-023 rsp_retries SHALL equal the number of re-issues of the responded operation (0..MAX_RETRY).

Reset
REQ-024 rst_n low SHALL immediately force IDLE; req_ready=1 after release; rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_fault=0, rsp_retries=0, alu_a=0, alu_b=0, alu_op=0, counters=0, last_err_flags=0.
REQ-025 Reset mid-operation SHALL abandon the operation with no response and no counter update.

Structure
REQ-026 Shared package SHALL hold ALU opcode constants, err-flag bit positions, FSM state encoding.
REQ-027 One sub-module sat_counter (width parameter, inc, clr) SHALL be instantiated for err_count and fault_count.

Verification
REQ-028 ADD 0x1234+0x0001, no error, rsp_ready=1 -> rsp_result=0x1235, rsp_fault=0, rsp_retries=0, rsp_valid after edge N+3.
REQ-029 alu_error=1 on first CHECK only, flags 4'b1000 -> one retry, rsp_retries=1, err_count=1, last_err_flags=4'b1000, rsp_fault=0, rsp_valid after edge N+5.
REQ-030 alu_error stuck high, MAX_RETRY=2 -> rsp_fault=1, rsp_retries=2, err_count=3, fault_count=1.
REQ-031 rsp_ready low 5 cycles -> rsp_* stable, req_ready=0 throughout, next request accepted only after handshake.
REQ-032 CNT_W=2, four faulting operations -> fault_count saturates at 3; clr_counts concurrent with an increment -> counts 0.
REQ-033 rst_n asserted during CHECK -> all outputs at reset values immediately, no response issued.
